// File: rtl/stream_checksum_if.sv
// Stream-in / result-out bundle for the ones-complement checksum engine.
// Input beats handshake on s_valid/s_ready and results on m_valid/m_ready.
// In both cases a transfer happens on a rising clock edge where valid and
// ready are both 1. Once a producer raises valid, it holds valid and its
// payload stable until that transfer.
interface stream_checksum_if #(
  parameter int DATA_W = 64
);
  localparam int NW = DATA_W / 16;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [NW-1:0]     s_keep;
  logic              s_last;
  logic [15:0]       init_sum;
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_checksum;
  logic              m_ok;
  logic [15:0]       m_words;

  // Checksum engine side
  modport slave (
    input  s_valid, s_data, s_keep, s_last, init_sum, m_ready,
    output s_ready, m_valid, m_checksum, m_ok, m_words
  );

  // Beat producer / result consumer side
  modport master (
    output s_valid, s_data, s_keep, s_last, init_sum, m_ready,
    input  s_ready, m_valid, m_checksum, m_ok, m_words
  );
endinterface

// File: rtl/stream_checksum.sv
// Internet-style ones-complement checksum over a packet of 16-bit words,
// with a per-packet seed, per-word keep mask and saturating word count.
// The result is presented until it is consumed. New beats are blocked
// while a result is pending.
module stream_checksum #(
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_checksum_if.slave   bus,
  output logic [1:0]         dbg_state
);
  localparam int NW = DATA_W / 16;
  localparam int CW = $clog2(NW + 1);
  localparam int SW = 16 + CW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] chk_q, chk_d;
  logic        ok_q, ok_d;
  logic [15:0] words_q, words_d;

  logic          s_fire;
  logic          m_fire;
  logic [15:0]   acc_base;
  logic [15:0]   cnt_base;
  logic [SW-1:0] raw_sum;
  logic [SW-1:0] folded;
  logic [15:0]   beat_sum;
  logic [CW-1:0] pop;
  logic [16:0]   cnt_sum;
  logic [15:0]   cnt_new;

  // Ready is decoded from the registered state only.
  assign bus.s_ready    = (state_q != HOLD);
  assign bus.m_valid    = valid_q;
  assign bus.m_checksum = chk_q;
  assign bus.m_ok       = ok_q;
  assign bus.m_words    = words_q;
  assign dbg_state      = state_q;

  assign s_fire = bus.s_valid && (state_q != HOLD);
  assign m_fire = valid_q && bus.m_ready;

  // Beat arithmetic: seed or running sum plus enabled words, then end-around fold.
  always_comb begin
    acc_base = (state_q == IDLE) ? bus.init_sum : acc_q;
    cnt_base = (state_q == IDLE) ? 16'd0 : cnt_q;
    raw_sum  = {{CW{1'b0}}, acc_base};
    pop      = '0;
    for (int i = 0; i < NW; i++) begin
      if (bus.s_keep[i]) begin
        raw_sum = raw_sum + {{CW{1'b0}}, bus.s_data[16*i +: 16]};
        pop     = pop + CW'(1);
      end
    end
    // The raw sum is at most (NW+1)*0xFFFF. The first fold leaves at most
    // 0xFFFF+NW, so a second fold always lands within 16 bits.
    folded = raw_sum;
    for (int f = 0; f < 2; f++) begin
      folded = {{CW{1'b0}}, folded[15:0]} + {16'd0, folded[SW-1:16]};
    end
    beat_sum = folded[15:0];
    cnt_sum  = {1'b0, cnt_base} + 17'(pop);
    cnt_new  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Next-state and registered-output decode for the IDLE/ACCUM/HOLD FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    chk_d   = chk_q;
    ok_d    = ok_q;
    words_d = words_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (s_fire) begin
          acc_d = beat_sum;
          cnt_d = cnt_new;
          if (bus.s_last) begin
            state_d = HOLD;
            valid_d = 1'b1;
            chk_d   = ~beat_sum;
            ok_d    = (beat_sum == 16'hFFFF);
            words_d = cnt_new;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // Result fields keep their last values after consumption.
        if (m_fire) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register; asynchronous reset discards any partial packet or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 16'd0;
      cnt_q   <= 16'd0;
      valid_q <= 1'b0;
      chk_q   <= 16'd0;
      ok_q    <= 1'b0;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      chk_q   <= chk_d;
      ok_q    <= ok_d;
      words_q <= words_d;
    end
  end
endmodule

// File: tb/tb_stream_checksum.sv
// Directed bench for stream_checksum at DATA_W=64 with hand-computed checksums.
module tb_stream_checksum;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  stream_checksum_if #(.DATA_W(64)) bus ();

  stream_checksum #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one beat and hold it until accepted; returns 1 time unit after the transfer edge.
  task automatic drive_beat(input logic [63:0] d, input logic [3:0] k, input logic l,
                            input logic [15:0] init);
    int n;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_keep   = k;
    bus.s_last   = l;
    bus.init_sum = init;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL beat_accept_timeout s_ready=%b required=1", bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Driver: consume the pending result with a one-cycle m_ready pulse.
  task automatic release_result();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_checksum !== 16'h0000) begin bad++; $display("FAIL rst_checksum got=%h exp=0000", bus.m_checksum); end
    total++; if (bus.m_ok !== 1'b0) begin bad++; $display("FAIL rst_m_ok got=%b exp=0", bus.m_ok); end
    total++; if (bus.m_words !== 16'h0000) begin bad++; $display("FAIL rst_words got=%h exp=0000", bus.m_words); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_single_beat();
    drive_beat({16'h4000, 16'h4422, 16'h0030, 16'h4500}, 4'b1111, 1'b1, 16'h0000);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid got=%b exp=1", bus.m_valid); end
    total++; if (bus.m_checksum !== 16'h36AD) begin bad++; $display("FAIL single_checksum got=%h exp=36ad", bus.m_checksum); end
    total++; if (bus.m_ok !== 1'b0) begin bad++; $display("FAIL single_m_ok got=%b exp=0", bus.m_ok); end
    total++; if (bus.m_words !== 16'd4) begin bad++; $display("FAIL single_words got=%0d exp=4", bus.m_words); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL single_s_ready got=%b exp=0", bus.s_ready); end
    release_result();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_carry();
    // 0xFFFF + 0x0001 = 0x10000 -> 0x0001; masked-off words are garbage
    drive_beat({16'hAAAA, 16'hAAAA, 16'h0001, 16'hFFFF}, 4'b0011, 1'b1, 16'h0000);
    total++; if (bus.m_checksum !== 16'hFFFE) begin bad++; $display("FAIL carry_checksum got=%h exp=fffe", bus.m_checksum); end
    total++; if (bus.m_words !== 16'd2) begin bad++; $display("FAIL carry_words got=%0d exp=2", bus.m_words); end
    total++; if (bus.m_ok !== 1'b0) begin bad++; $display("FAIL carry_m_ok got=%b exp=0", bus.m_ok); end
    release_result();
    // 0xFFFF seed + 0xFFFF + 0x0001 = 0x1FFFF -> 0x10000 -> 0x0001 (needs two folds)
    drive_beat({16'h5555, 16'h5555, 16'h0001, 16'hFFFF}, 4'b0011, 1'b1, 16'hFFFF);
    total++; if (bus.m_checksum !== 16'hFFFE) begin bad++; $display("FAIL dfold_checksum got=%h exp=fffe", bus.m_checksum); end
    release_result();
  endtask

  task automatic test_verify();
    drive_beat({48'h0, 16'h1234}, 4'b0001, 1'b0, 16'h0000);
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL verify_accum_state got=%0d exp=1", dbg_state); end
    // The seed on a non-first beat is ignored.
    drive_beat({48'h0, 16'hEDCB}, 4'b0001, 1'b1, 16'h1111);
    total++; if (bus.m_checksum !== 16'h0000) begin bad++; $display("FAIL verify_checksum got=%h exp=0000", bus.m_checksum); end
    total++; if (bus.m_ok !== 1'b1) begin bad++; $display("FAIL verify_m_ok got=%b exp=1", bus.m_ok); end
    total++; if (bus.m_words !== 16'd2) begin bad++; $display("FAIL verify_words got=%0d exp=2", bus.m_words); end
    release_result();
  endtask

  task automatic test_hold();
    drive_beat({48'h0, 16'h8000}, 4'b0001, 1'b1, 16'h8000);
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL hold_m_valid c=%0d got=%b exp=1", c, bus.m_valid); end
      total++; if (bus.m_checksum !== 16'hFFFE) begin bad++; $display("FAIL hold_checksum c=%0d got=%h exp=fffe", c, bus.m_checksum); end
      total++; if (bus.m_words !== 16'd1) begin bad++; $display("FAIL hold_words c=%0d got=%0d exp=1", c, bus.m_words); end
      total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL hold_s_ready c=%0d got=%b exp=0", c, bus.s_ready); end
      @(posedge clk); #1;
    end
    release_result();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b exp=1", bus.s_ready); end
    total++; if (bus.m_checksum !== 16'hFFFE) begin bad++; $display("FAIL hold_kept_checksum got=%h exp=fffe", bus.m_checksum); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL hold_release_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_idle_gap();
    drive_beat({48'h0, 16'h0102}, 4'b0001, 1'b0, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (dbg_state !== 2'd1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
        bad++; $display("FAIL gap_hold c=%0d state=%0d m_valid=%b s_ready=%b exp=1/0/1", c, dbg_state, bus.m_valid, bus.s_ready);
      end
    end
    // 0x0102 + 0x0304 + 0x1000 = 0x1406; middle words masked
    drive_beat({16'h1000, 16'hFFFF, 16'hFFFF, 16'h0304}, 4'b1001, 1'b1, 16'h7777);
    total++; if (bus.m_checksum !== 16'hEBF9) begin bad++; $display("FAIL gap_checksum got=%h exp=ebf9", bus.m_checksum); end
    total++; if (bus.m_words !== 16'd3) begin bad++; $display("FAIL gap_words got=%0d exp=3", bus.m_words); end
    release_result();
  endtask

  task automatic test_reset_mid();
    drive_beat({48'h0, 16'h1111}, 4'b0001, 1'b0, 16'h2222);
    drive_beat({32'h0, 16'h3333, 16'h4444}, 4'b0011, 1'b0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rmid_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_checksum !== 16'h0000) begin bad++; $display("FAIL rmid_checksum got=%h exp=0000", bus.m_checksum); end
    total++; if (bus.m_words !== 16'h0000) begin bad++; $display("FAIL rmid_words got=%h exp=0000", bus.m_words); end
    total++; if (bus.m_ok !== 1'b0) begin bad++; $display("FAIL rmid_m_ok got=%b exp=0", bus.m_ok); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", dbg_state); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat({48'h0, 16'h0001}, 4'b0001, 1'b1, 16'h0000);
    total++; if (bus.m_checksum !== 16'hFFFE) begin bad++; $display("FAIL rmid_after_checksum got=%h exp=fffe", bus.m_checksum); end
    total++; if (bus.m_words !== 16'd1) begin bad++; $display("FAIL rmid_after_words got=%0d exp=1", bus.m_words); end
    release_result();
  endtask

  task automatic test_zero_keep();
    for (int b = 0; b < 3; b++) begin
      drive_beat(64'h1234_5678_9ABC_DEF0, 4'b0000, 1'b0, 16'h0000);
    end
    drive_beat(64'hFEDC_BA98_7654_3210, 4'b0000, 1'b1, 16'h0000);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL zero_m_valid got=%b exp=1", bus.m_valid); end
    total++; if (bus.m_checksum !== 16'hFFFF) begin bad++; $display("FAIL zero_checksum got=%h exp=ffff", bus.m_checksum); end
    total++; if (bus.m_ok !== 1'b0) begin bad++; $display("FAIL zero_m_ok got=%b exp=0", bus.m_ok); end
    total++; if (bus.m_words !== 16'd0) begin bad++; $display("FAIL zero_words got=%0d exp=0", bus.m_words); end
    release_result();
  endtask

  task automatic test_saturation();
    // 16400 beats * 4 words = 65600 words, clamps at 0xFFFF
    int stalls;
    stalls = 0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 64'h0;
    bus.s_keep   = 4'b1111;
    bus.init_sum = 16'h0000;
    for (int i = 0; i < 16400; i++) begin
      bus.s_last = (i == 16399);
      if (bus.s_ready !== 1'b1) stalls++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    total++; if (stalls != 0) begin bad++; $display("FAIL sat_stalls got=%0d exp=0", stalls); end
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL sat_m_valid got=%b exp=1", bus.m_valid); end
    total++; if (bus.m_words !== 16'hFFFF) begin bad++; $display("FAIL sat_words got=%h exp=ffff", bus.m_words); end
    total++; if (bus.m_checksum !== 16'hFFFF) begin bad++; $display("FAIL sat_checksum got=%h exp=ffff", bus.m_checksum); end
    release_result();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_keep   = '0;
    bus.s_last   = 1'b0;
    bus.init_sum = '0;
    bus.m_ready  = 1'b0;
    test_reset();
    test_single_beat();
    test_carry();
    test_verify();
    test_hold();
    test_idle_gap();
    test_reset_mid();
    test_zero_keep();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_checksum.md
STREAM_CHECKSUM -- requirements
Module: stream_checksum

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the beat width in bits; it SHALL be a multiple of 16 and ≥16.
REQ-002 The block SHALL derive NW = DATA_W/16, the number of 16-bit words per beat.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: the input beat is valid.
REQ-006 The block SHALL have port s_ready, output, 1 bit: the block accepts a beat; a beat transfers when s_valid&s_ready.
REQ-007 The block SHALL have port s_data, input, DATA_W bits: word i = s_data[16i+15:16i].
REQ-008 The block SHALL have port s_keep, input, NW bits: bit i enables word i; disabled words contribute 0.
REQ-009 The block SHALL have port s_last, input, 1 bit: the final beat of a packet.
REQ-010 The block SHALL have port init_sum, input, 16 bits: the seed (e.g. pseudo-header sum), sampled on the first beat of each packet only.
REQ-011 The block SHALL have port m_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port m_checksum, output, 16 bits: the ones-complement of the folded sum.
REQ-014 The block SHALL have port m_ok, output, 1 bit: 1 when the folded sum == 0xFFFF (verify pass).
REQ-015 The block SHALL have port m_words, output, 16 bits: the count of enabled words in the packet, saturating at 0xFFFF.

Function
REQ-016 The block SHALL have FSM states IDLE (awaiting first beat), ACCUM (mid-packet) and HOLD (result presented).
REQ-017 s_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, decoded from registered state only.
REQ-018 On an accepted beat in IDLE, the accumulator base SHALL be init_sum; in ACCUM it SHALL be the current accumulator.
REQ-019 Beat sum SHALL be the base plus all enabled words, computed at ≥16+clog2(NW+1) bits, then end-around-carry folded (hi+lo, repeated until ≤16 bits) before registering; the accumulator SHALL always hold a 16-bit value.
REQ-020 An accepted beat without s_last SHALL move IDLE→ACCUM or stay in ACCUM.
REQ-021 An accepted beat with s_last (from IDLE or ACCUM) SHALL move to HOLD next cycle, with m_valid=1, m_checksum=~sum, m_ok=(sum==0xFFFF), and m_words registered in the same edge; latency is 1 cycle from the last beat to m_valid.
REQ-022 A single-beat packet (first beat with s_last) SHALL be legal.
REQ-023 In HOLD, outputs SHALL remain stable until m_valid&m_ready; on that edge the block SHALL go to IDLE with m_valid=0, and m_checksum/m_ok/m_words SHALL hold their last values.
REQ-024 A beat with s_keep all zero SHALL be legal: it adds 0 and advances the FSM normally.
REQ-025 The word count SHALL add popcount(s_keep) per beat and saturate at 0xFFFF without wrap.
REQ-026 s_valid low in ACCUM SHALL hold all state, with no timeout.
REQ-027 The block SHALL NOT normalise a result of 0x0000 to 0xFFFF.

Reset
REQ-028 While rst_n=0 the block SHALL be in state IDLE with accumulator 0, word count 0, m_valid 0, m_checksum 0, m_ok 0 and m_words 0; s_ready SHALL be 1 after reset.
REQ-029 Reset mid-packet or in HOLD SHALL discard the partial packet or pending result; the first beat after release SHALL be treated as a packet start.

Verification
REQ-030 The bench SHALL cover: DATA_W=64, init 0, one beat of words 0x4500,0x0030,0x4422,0x4000, keep 1111, last → next cycle m_valid=1, m_checksum=0x36AD, m_ok=0, m_words=4.
REQ-031 The bench SHALL cover: words 0xFFFF,0x0001, keep 0011, last → sum 0x0001, m_checksum=0xFFFE, m_words=2.
REQ-032 The bench SHALL cover a verify pass: beat 1 word 0x1234 keep 0001, beat 2 word 0xEDCB keep 0001 last → m_checksum=0x0000, m_ok=1, m_words=2.
REQ-033 The bench SHALL cover: init_sum=0x8000, words 0x8000 (keep 0001, last) → fold 0x10000→0x0001, m_checksum=0xFFFE; then m_ready low 5 cycles → outputs stable, s_ready=0; m_ready high → IDLE, s_ready=1 next cycle.
REQ-034 The bench SHALL cover: two beats accepted, rst_n pulsed low asynchronously between clocks → all outputs 0 immediately; next packet 0x0001 last → m_checksum=0xFFFE, m_words=1.
REQ-035 The bench SHALL cover: three beats with keep 0000 then last keep 0000 → m_checksum=0xFFFF, m_ok=0, m_words=0.
